// File: rtl/zx_bus_responder_if.sv
// Z80-style CPU bus plus a simple request/ack memory backend, seen from the responder (slave)
// and from the CPU/backend side (master).
interface zx_bus_responder_if;
    logic [15:0] A;
    logic [7:0]  cpu_do;
    logic        mreq_n;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic        rfsh_n;
    logic [7:0]  di;
    logic        wait_n;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport slave (
        input  A, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, mem_ack, mem_rdata,
        output di, wait_n, mem_addr, mem_wdata, mem_we, mem_req
    );

    modport master (
        output A, cpu_do, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, mem_ack, mem_rdata,
        input  di, wait_n, mem_addr, mem_wdata, mem_we, mem_req
    );
endinterface

// File: rtl/zx_bus_responder.sv
// Bridges Z80 memory cycles to a req/ack backend; the ZXBUS_IOPORT_EN macro adds the ULA border/keyboard port.
// The CPU is held in wait from the start strobe until mem_ack, plus WAIT_STATES extra cycles.
module zx_bus_responder #(
    parameter int         WAIT_STATES = 0,
    parameter logic [7:0] IM2_VECTOR  = 8'hFF
) (
    input  logic clk,
    input  logic reset,
`ifdef ZXBUS_IOPORT_EN
    input  logic [4:0] kbd,
    output logic [2:0] border,
`endif
    zx_bus_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COUNT, REQ, HOLD} state_t;

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        mem_we_q;
    logic [7:0]  di_q;
    logic [7:0]  io_rd_dat;

    logic start_cond;
    logic start;
    logic io_cyc;
    logic inta;
    logic io_rd;

    assign start_cond = ~bus.mreq_n & bus.rfsh_n & (~bus.rd_n | ~bus.wr_n);
    assign start      = (state == IDLE) && start_cond;
    assign io_cyc     = ~bus.iorq_n & bus.m1_n;
    assign inta       = ~bus.iorq_n & ~bus.m1_n;
    assign io_rd      = io_cyc & ~bus.rd_n;

`ifdef ZXBUS_IOPORT_EN
    assign io_rd_dat = bus.A[0] ? 8'hFF : {3'b111, kbd};
`else
    assign io_rd_dat = 8'hFF;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start_cond) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = COUNT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            COUNT: begin
                if (cnt == 4'd0) state_nxt = REQ;
                else             cnt_nxt   = cnt - 4'd1;
            end
            // Once issued, a request always runs to its ack even if the strobe goes away.
            REQ:     if (bus.mem_ack) state_nxt = HOLD;
            HOLD:    if (bus.mreq_n)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            di_q        <= 8'hFF;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state_nxt == REQ && state != REQ) begin
                mem_addr_q  <= bus.A;
                mem_wdata_q <= bus.cpu_do;
                mem_we_q    <= ~bus.wr_n;
            end
            if (state == REQ && bus.mem_ack && !mem_we_q) di_q <= bus.mem_rdata;
            else if (inta)                                 di_q <= IM2_VECTOR;
            else if (io_rd)                                di_q <= io_rd_dat;
        end
    end

`ifdef ZXBUS_IOPORT_EN
    logic io_wr;
    logic io_wr_q;

    assign io_wr = io_cyc & ~bus.wr_n;

    // Border latches once per OUT, on the first edge the write strobe is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_wr_q <= 1'b0;
            border  <= 3'd0;
        end else begin
            io_wr_q <= io_wr;
            if (io_wr && !io_wr_q && !bus.A[0]) border <= bus.cpu_do[2:0];
        end
    end
`endif

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.di        = di_q;
    assign bus.wait_n    = reset ? 1'b1 : ~(start || state == COUNT || state == REQ);

endmodule

// File: tb/tb_zx_bus_responder.sv
// Two responders (0 and 3 wait states) share one CPU bus; each has its own backend,
// and every access is scored against wait/request counts derived from the bus rules.
module tb_zx_bus_responder;
    localparam int         W0 = 0;
    localparam int         W3 = 3;
    localparam logic [7:0] V0 = 8'hE7;
    localparam logic [7:0] V3 = 8'h42;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] a_r;
    logic [7:0]  do_r;
    logic        mreq_r, iorq_r, rd_r, wr_r, m1_r, rfsh_r;
    logic        ack_r  [2];
    logic [7:0]  rdat_r [2];

    zx_bus_responder_if bus0 ();
    zx_bus_responder_if bus3 ();

    assign bus0.A = a_r;        assign bus3.A = a_r;
    assign bus0.cpu_do = do_r;  assign bus3.cpu_do = do_r;
    assign bus0.mreq_n = mreq_r; assign bus3.mreq_n = mreq_r;
    assign bus0.iorq_n = iorq_r; assign bus3.iorq_n = iorq_r;
    assign bus0.rd_n = rd_r;    assign bus3.rd_n = rd_r;
    assign bus0.wr_n = wr_r;    assign bus3.wr_n = wr_r;
    assign bus0.m1_n = m1_r;    assign bus3.m1_n = m1_r;
    assign bus0.rfsh_n = rfsh_r; assign bus3.rfsh_n = rfsh_r;
    assign bus0.mem_ack = ack_r[0];    assign bus3.mem_ack = ack_r[1];
    assign bus0.mem_rdata = rdat_r[0]; assign bus3.mem_rdata = rdat_r[1];

`ifdef ZXBUS_IOPORT_EN
    logic [4:0] kbd_r;
    logic [2:0] border0, border3;
    zx_bus_responder #(.WAIT_STATES(W0), .IM2_VECTOR(V0)) dut0 (
        .clk(clk), .reset(reset), .kbd(kbd_r), .border(border0), .bus(bus0));
    zx_bus_responder #(.WAIT_STATES(W3), .IM2_VECTOR(V3)) dut3 (
        .clk(clk), .reset(reset), .kbd(kbd_r), .border(border3), .bus(bus3));
`else
    zx_bus_responder #(.WAIT_STATES(W0), .IM2_VECTOR(V0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    zx_bus_responder #(.WAIT_STATES(W3), .IM2_VECTOR(V3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3));
`endif

    int tests = 0;
    int fails = 0;

    // sampled outputs, per-access statistics and the reference model state
    logic        s_req [2], s_wait [2], s_we [2];
    logic [7:0]  s_di [2], s_wd [2];
    logic [15:0] s_addr [2];
    int          wait_lo [2], req_cyc [2], req_rise [2], bk_cnt [2];
    logic        prev_req [2], seen [2], acked [2], cap_we [2];
    logic [15:0] cap_addr [2];
    logic [7:0]  cap_wd [2];
    logic [7:0]  di_model [2];
    int          bk_delay;
    logic        bk_en, force_ack;

    function automatic logic [7:0] rd_val(input logic [15:0] a);
        return (a == 16'h4000) ? 8'h5A : (a[15:8] ^ a[7:0] ^ 8'hA5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge after inputs are driven; samples, runs the backends, returns at the next falling edge.
    task automatic cyc();
        #1;
        s_req[0] = bus0.mem_req;  s_req[1] = bus3.mem_req;
        s_wait[0] = bus0.wait_n;  s_wait[1] = bus3.wait_n;
        s_di[0] = bus0.di;        s_di[1] = bus3.di;
        s_addr[0] = bus0.mem_addr; s_addr[1] = bus3.mem_addr;
        s_we[0] = bus0.mem_we;    s_we[1] = bus3.mem_we;
        s_wd[0] = bus0.mem_wdata; s_wd[1] = bus3.mem_wdata;
        for (int k = 0; k < 2; k++) begin
            if (!s_wait[k]) wait_lo[k]++;
            if (s_req[k]) begin
                req_cyc[k]++;
                seen[k] = 1'b1;
                if (!prev_req[k]) req_rise[k]++;
            end
            prev_req[k] = s_req[k];
            ack_r[k] = 1'b0;
            if (force_ack) begin
                ack_r[k]  = 1'b1;
                rdat_r[k] = 8'h99;
            end else if (bk_en && s_req[k]) begin
                bk_cnt[k]++;
                if (bk_cnt[k] == bk_delay + 1) begin
                    ack_r[k]    = 1'b1;
                    rdat_r[k]   = rd_val(s_addr[k]);
                    acked[k]    = 1'b1;
                    cap_addr[k] = s_addr[k];
                    cap_we[k]   = s_we[k];
                    cap_wd[k]   = s_wd[k];
                end
            end else begin
                bk_cnt[k] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 2; k++) begin
            wait_lo[k] = 0; req_cyc[k] = 0; req_rise[k] = 0; bk_cnt[k] = 0;
            seen[k] = 1'b0; acked[k] = 1'b0; prev_req[k] = 1'b0;
        end
    endtask

    task automatic release_bus();
        mreq_r = 1'b1; iorq_r = 1'b1; rd_r = 1'b1; wr_r = 1'b1; m1_r = 1'b1; rfsh_r = 1'b1;
    endtask

    // One memory access; 'early' drops the strobes as soon as both responders have raised mem_req.
    task automatic access(input logic is_wr, input logic [15:0] a, input logic [7:0] d,
                          input int dly, input logic early);
        int   n = 0;
        int   post = 0;
        int   hold;
        int   w;
        logic rel = 1'b0;
        clear_stats();
        bk_delay = dly;
        bk_en    = 1'b1;
        hold     = W3 + dly + 2 + int'($urandom_range(0, 3));
        a_r = a; do_r = d; mreq_r = 1'b0; rd_r = is_wr; wr_r = ~is_wr;
        while (1) begin
            cyc();
            n++;
            if (rel) begin
                if (acked[0] && acked[1]) post++;
                if (post == 2) break;
            end else if (early ? (seen[0] && seen[1]) : (acked[0] && acked[1] && n >= hold)) begin
                release_bus();
                rel = 1'b1;
            end
            if (n >= 80) begin
                chk("access_timeout", {30'd0, acked[1], acked[0]}, 32'd3);
                release_bus();
                break;
            end
        end
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? W0 : W3;
            chk($sformatf("wait_cycles[%0d] a=%h", k, a), wait_lo[k], w + dly + 2);
            chk($sformatf("req_cycles[%0d] a=%h", k, a), req_cyc[k], dly + 1);
            chk($sformatf("req_count[%0d] a=%h", k, a), req_rise[k], 1);
            chk($sformatf("mem_addr[%0d]", k), cap_addr[k], a);
            chk($sformatf("mem_we[%0d] a=%h", k, a), cap_we[k], is_wr);
            if (is_wr) chk($sformatf("mem_wdata[%0d] a=%h", k, a), cap_wd[k], d);
            else       di_model[k] = rd_val(a);
            chk($sformatf("di[%0d] a=%h", k, a), s_di[k], di_model[k]);
            chk($sformatf("addr_hold[%0d]", k), s_addr[k], a);
        end
    endtask

    task automatic quiet_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk(tag, {s_wait[1], s_wait[0], s_req[1], s_req[0]}, 4'b1100);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        release_bus();
        reset = 1'b1; a_r = 16'h0000; do_r = 8'h00;
        bk_en = 1'b1; force_ack = 1'b0; bk_delay = 0;
        ack_r[0] = 1'b0; ack_r[1] = 1'b0; rdat_r[0] = 8'h00; rdat_r[1] = 8'h00;
`ifdef ZXBUS_IOPORT_EN
        kbd_r = 5'b11111;
`endif
        clear_stats();
        @(negedge clk);

        // reset state, with a read strobe asserted to show wait_n is forced high
        cyc(); cyc();
        mreq_r = 1'b0; rd_r = 1'b0;
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_wait[%0d]", k), s_wait[k], 1'b1);
            chk($sformatf("rst_req[%0d]", k), s_req[k], 1'b0);
            chk($sformatf("rst_di[%0d]", k), s_di[k], 8'hFF);
            chk($sformatf("rst_mem[%0d]", k), {s_addr[k], s_wd[k], 7'd0, s_we[k]}, 32'd0);
            di_model[k] = 8'hFF;
        end
        release_bus();
        cyc();
        reset = 1'b0;
        cyc();

        access(1'b0, 16'h4000, 8'h00, 0, 1'b0);
        access(1'b1, 16'h8001, 8'hC3, 0, 1'b0);
        access(1'b0, 16'h2345, 8'h00, 3, 1'b1);

        mreq_r = 1'b0; rfsh_r = 1'b0; a_r = 16'h3F7E;
        quiet_cycles("refresh", 4);
        release_bus();
        cyc();

        m1_r = 1'b0; iorq_r = 1'b0;
        quiet_cycles("inta", 2);
        release_bus();
        cyc();
        di_model[0] = V0; di_model[1] = V3;
        chk("inta_di[0]", s_di[0], V0);
        chk("inta_di[1]", s_di[1], V3);

        a_r = 16'h00FE; do_r = 8'h05; iorq_r = 1'b0; wr_r = 1'b0;
        quiet_cycles("io_write", 2);
        release_bus();
        cyc();
`ifdef ZXBUS_IOPORT_EN
        chk("border[0]", border0, 3'd5);
        chk("border[1]", border3, 3'd5);
        kbd_r = 5'b10110;
`endif
        a_r = 16'h7FFE; iorq_r = 1'b0; rd_r = 1'b0;
        quiet_cycles("io_read", 2);
        release_bus();
        cyc();
`ifdef ZXBUS_IOPORT_EN
        chk("io_kbd_di[0]", s_di[0], 8'hF6);
        chk("io_kbd_di[1]", s_di[1], 8'hF6);
        a_r = 16'h00FF; iorq_r = 1'b0; rd_r = 1'b0;
        quiet_cycles("io_read_odd", 2);
        release_bus();
        cyc();
`endif
        chk("io_di[0]", s_di[0], 8'hFF);
        chk("io_di[1]", s_di[1], 8'hFF);

        access(1'b0, 16'h1357, 8'h00, 1, 1'b0);

        // reset while dut0 is in REQ, then an ack that arrives too late
        bk_en = 1'b0;
        clear_stats();
        a_r = 16'h1234; mreq_r = 1'b0; rd_r = 1'b0;
        for (int n = 0; n < 20 && !s_req[0]; n++) cyc();
        chk("rst_mid_reached_req", s_req[0], 1'b1);
        reset = 1'b1;
        release_bus();
        cyc();
        chk("rst_mid_wait", {s_wait[1], s_wait[0]}, 2'b11);
        reset = 1'b0;
        cyc();
        chk("rst_mid_req", {s_req[1], s_req[0]}, 2'b00);
        force_ack = 1'b1;
        cyc();
        force_ack = 1'b0;
        cyc();
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("late_ack_req[%0d]", k), s_req[k], 1'b0);
            chk($sformatf("late_ack_di[%0d]", k), s_di[k], 8'hFF);
            chk($sformatf("late_ack_wait[%0d]", k), s_wait[k], 1'b1);
            di_model[k] = 8'hFF;
        end
        bk_en = 1'b1;

        for (int i = 0; i < 24; i++) begin
            access(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/zx_bus_responder.md
ZX_BUS_RESPONDER -- requirements
Module: zx_bus_responder

Interface
REQ-001 Parameters SHALL be: WAIT_STATES, default 0, minimum wait cycles added per memory access (0..15); IM2_VECTOR, default 8'hFF, byte returned on interrupt acknowledge.
REQ-002 Ports SHALL be: clk  in  1  single clock, also the CPU clock; reset  in  1  synchronous active-high reset.
REQ-003 CPU side SHALL be: A  in  16  address; cpu_do  in  8  CPU write data; mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n  in  1 each  CPU strobes (driven on the falling clk edge); di  out  8  CPU read data; wait_n  out  1  wait request.
REQ-004 Memory side SHALL be: mem_addr  out  16; mem_wdata  out  8; mem_we  out  1  write qualifier; mem_req  out  1  request; mem_ack  in  1  one-cycle completion pulse; mem_rdata  in  8  valid in the mem_ack cycle.
REQ-005 With ZXBUS_IOPORT_EN defined, SHALL add: kbd  in  5  key columns (active-low); border  out  3  border colour.

Function
REQ-006 Memory start condition SHALL be: mreq_n=0, rfsh_n=1, (rd_n=0 or wr_n=0), sampled on rising clk while FSM in IDLE.
REQ-007 FSM states SHALL be IDLE, COUNT, REQ, HOLD; IDLE->COUNT on start when WAIT_STATES>0, else IDLE->REQ.
REQ-008 COUNT SHALL decrement a 4-bit counter loaded with WAIT_STATES-1, moving to REQ when it reaches 0.
REQ-009 On entering REQ, mem_addr, mem_wdata (=cpu_do), mem_we (=~wr_n) SHALL be registered and held stable until mem_ack.
REQ-010 mem_req SHALL be 1 exactly while in REQ; mem_ack while in REQ SHALL move FSM to HOLD; mem_ack outside REQ SHALL be ignored.
REQ-011 On a read ack, di SHALL register mem_rdata in the ack cycle and hold it until the next access completes.
REQ-012 wait_n SHALL be combinational: 0 when start condition is present in IDLE, or FSM in COUNT or REQ; 1 otherwise.
REQ-013 HOLD SHALL return to IDLE on the first rising edge with mreq_n=1; a strobe continuously asserted SHALL never start a second access.
REQ-014 Strobe released before mem_ack SHALL NOT abort: mem_req stays 1 until ack, then FSM goes HOLD->IDLE.
REQ-015 Refresh cycles (rfsh_n=0) SHALL generate no request and no wait.
REQ-016 Interrupt acknowledge (m1_n=0, iorq_n=0) SHALL set di=IM2_VECTOR the same cycle it is sampled, with no memory request and wait_n=1.
REQ-017 I/O cycles (iorq_n=0, m1_n=1) SHALL insert no waits and no memory request; without ZXBUS_IOPORT_EN, I/O reads SHALL set di=8'hFF.
REQ-018 mem_addr, mem_wdata, mem_we SHALL hold last values outside REQ.

Reset
REQ-019 While reset=1 at a rising edge: FSM=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, di=8'hFF, border=0; wait_n SHALL read 1 while reset=1.
REQ-020 Reset mid-access SHALL drop mem_req in the following cycle; a late mem_ack SHALL be ignored.

Configuration
REQ-021 Macro ZXBUS_IOPORT_EN SHALL compile in the ULA port: I/O write with A[0]=0 latches cpu_do[2:0] into border on the rising edge where wr_n=0 is first sampled; I/O read with A[0]=0 sets di={3'b111, kbd}; other I/O reads return 8'hFF.
REQ-022 Without ZXBUS_IOPORT_EN, kbd and border ports SHALL be absent and all I/O writes ignored.

Verification
REQ-023 WAIT_STATES=0, read A=16'h4000, backend acks 1 cycle after mem_req with 8'h5A -> mem_req high 1 cycle... wait_n low 2 cycles, di=8'h5A, one request only.
REQ-024 WAIT_STATES=3, write A=16'h8001 cpu_do=8'hC3, immediate ack -> 3 COUNT cycles, then mem_req with mem_we=1, mem_wdata=8'hC3, mem_addr=16'h8001.
REQ-025 Refresh (mreq_n=0, rfsh_n=0, rd_n=1) -> mem_req stays 0, wait_n stays 1.
REQ-026 Interrupt acknowledge, IM2_VECTOR=8'hE7 -> di=8'hE7, no mem_req, wait_n=1.
REQ-027 Reset asserted while in REQ, mem_ack arrives 2 cycles later -> mem_req 0 after one cycle, di=8'hFF, FSM IDLE, late ack no effect.
REQ-028 ZXBUS_IOPORT_EN defined: OUT to port 16'h00FE with 8'h05 then IN from 16'h7FFE with kbd=5'b10110 -> border=3'd5, di=8'hF6.
